// File: rtl/enigma_step_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : enigma_step_ctrl_if
// Description : Keystroke, rotor and cipher-return signals of the step controller
// Revision    : 1.0 - initial release
// ============================================================================
interface enigma_step_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             set_req;
    logic [14:0]      init_pos_in;
    logic             rotor_set_out;
    logic [14:0]      rotor_init_out;
    logic [4:0]       pos_r_in;
    logic [4:0]       pos_m_in;
    logic [4:0]       pos_l_in;
    logic             step_r_out;
    logic             step_m_out;
    logic             step_l_out;
    logic             in_valid;
    logic [4:0]       in_char;
    logic             in_ready;
    logic [4:0]       path_char_out;
    logic [4:0]       path_char_in;
    logic             out_valid;
    logic [4:0]       out_char;
    logic             out_ready;
    logic             err_pulse;
    logic [CNT_W-1:0] char_count;

    modport master (
        input  set_req, init_pos_in, pos_r_in, pos_m_in, pos_l_in,
               in_valid, in_char, path_char_in, out_ready,
        output rotor_set_out, rotor_init_out, step_r_out, step_m_out, step_l_out,
               in_ready, path_char_out, out_valid, out_char, err_pulse, char_count
    );

    modport slave (
        output set_req, init_pos_in, pos_r_in, pos_m_in, pos_l_in,
               in_valid, in_char, path_char_in, out_ready,
        input  rotor_set_out, rotor_init_out, step_r_out, step_m_out, step_l_out,
               in_ready, path_char_out, out_valid, out_char, err_pulse, char_count
    );
endinterface
`default_nettype wire

// File: rtl/enigma_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : enigma_step_ctrl
// Description : Enigma keystroke sequencer: rotor stepping, path timing, SET load
// Revision    : 1.0 - initial release
// ============================================================================
module enigma_step_ctrl #(
    parameter int NOTCH_R = 16,
    parameter int NOTCH_M = 4,
    parameter int CNT_W   = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    enigma_step_ctrl_if.master bus
);

    localparam logic [2:0] c_idle    = 3'd0;
    localparam logic [2:0] c_load    = 3'd1;
    localparam logic [2:0] c_step    = 3'd2;
    localparam logic [2:0] c_settle  = 3'd3;
    localparam logic [2:0] c_capture = 3'd4;
    localparam logic [2:0] c_out     = 3'd5;

    localparam logic [4:0] c_letters = 5'd26;
    localparam logic [4:0] c_notch_r = 5'(NOTCH_R);
    localparam logic [4:0] c_notch_m = 5'(NOTCH_M);

    logic [2:0]       r_state;
    logic [4:0]       r_letter;
    logic [14:0]      r_init;
    logic             r_set_pulse;
    logic             r_err_pulse;
    logic             r_in_ready;
    logic [4:0]       r_path_char;
    logic             r_out_valid;
    logic [4:0]       r_out_char;
    logic [CNT_W-1:0] r_char_count;

    logic w_in_step;
    logic w_notch_r;
    logic w_notch_m;

    // Step enables depend on the positions seen during STEP itself, so they
    // are decoded from the registered state rather than registered again.
    assign w_in_step = (r_state == c_step);
    assign w_notch_r = (bus.pos_r_in == c_notch_r);
    assign w_notch_m = (bus.pos_m_in == c_notch_m);

    assign bus.step_r_out     = w_in_step;
    assign bus.step_m_out     = w_in_step & (w_notch_r | w_notch_m);
    assign bus.step_l_out     = w_in_step & w_notch_m;
    assign bus.rotor_set_out  = r_set_pulse;
    assign bus.rotor_init_out = r_init;
    assign bus.in_ready       = r_in_ready;
    assign bus.path_char_out  = r_path_char;
    assign bus.out_valid      = r_out_valid;
    assign bus.out_char       = r_out_char;
    assign bus.err_pulse      = r_err_pulse;
    assign bus.char_count     = r_char_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_idle;
            r_letter     <= '0;
            r_init       <= '0;
            r_set_pulse  <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_in_ready   <= 1'b0;
            r_path_char  <= '0;
            r_out_valid  <= 1'b0;
            r_out_char   <= '0;
            r_char_count <= '0;
        end else begin
            r_set_pulse <= 1'b0;
            r_err_pulse <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (bus.set_req) begin
                        r_state      <= c_load;
                        r_init       <= bus.init_pos_in;
                        r_set_pulse  <= 1'b1;
                        r_char_count <= '0;
                        r_in_ready   <= 1'b0;
                    end else if (bus.in_valid && r_in_ready) begin
                        if (bus.in_char < c_letters) begin
                            r_state    <= c_step;
                            r_letter   <= bus.in_char;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_err_pulse <= 1'b1;
                            r_in_ready  <= 1'b1;
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                c_load: begin
                    r_state    <= c_idle;
                    r_in_ready <= 1'b1;
                end
                c_step: begin
                    r_state     <= c_settle;
                    r_path_char <= r_letter;
                end
                c_settle: begin
                    r_state <= c_capture;
                end
                c_capture: begin
                    r_state      <= c_out;
                    r_out_char   <= bus.path_char_in;
                    r_char_count <= r_char_count + CNT_W'(1);
                    r_out_valid  <= 1'b1;
                end
                c_out: begin
                    if (bus.out_ready) begin
                        r_state     <= c_idle;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= c_idle;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_enigma_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_enigma_step_ctrl
// Description : Directed and randomized bench with rotor model and reference
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enigma_step_ctrl;

    localparam int C_NR = 16;
    localparam int C_NM = 4;

    logic clk = 1'b0;
    logic reset;
    int   vectors    = 0;
    int   miscompares = 0;

    // Rotor environment and the independent expectation of where it should be
    int env_l = 0, env_m = 0, env_r = 0;
    int ref_l = 0, ref_m = 0, ref_r = 0, ref_count = 0;

    always #5 clk = ~clk;

    enigma_step_ctrl_if #(.CNT_W(16)) bus ();

    enigma_step_ctrl #(.NOTCH_R(C_NR), .NOTCH_M(C_NM), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic int chain(int c, int l, int m, int r);
        return (c + 10 + r + 2 * m + 3 * l) % 26;
    endfunction

    always @(posedge clk) begin
        if (bus.rotor_set_out) begin
            env_l <= int'(bus.rotor_init_out[14:10]);
            env_m <= int'(bus.rotor_init_out[9:5]);
            env_r <= int'(bus.rotor_init_out[4:0]);
        end else begin
            if (bus.step_r_out) env_r <= (env_r + 1) % 26;
            if (bus.step_m_out) env_m <= (env_m + 1) % 26;
            if (bus.step_l_out) env_l <= (env_l + 1) % 26;
        end
    end

    assign bus.pos_l_in     = 5'(env_l);
    assign bus.pos_m_in     = 5'(env_m);
    assign bus.pos_r_in     = 5'(env_r);
    assign bus.path_char_in = 5'(chain(int'(bus.path_char_out), env_l, env_m, env_r));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_steps(input string tag, input int sr, input int sm, input int sl);
        check({tag, "_step_r"}, 32'(bus.step_r_out), 32'(sr));
        check({tag, "_step_m"}, 32'(bus.step_m_out), 32'(sm));
        check({tag, "_step_l"}, 32'(bus.step_l_out), 32'(sl));
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic do_set(input int l, input int m, input int r);
        wait_ready();
        bus.set_req     = 1'b1;
        bus.init_pos_in = {5'(l), 5'(m), 5'(r)};
        @(negedge clk);
        bus.set_req = 1'b0;
        check("set_pulse", 32'(bus.rotor_set_out), 32'd1);
        check("set_init", 32'(bus.rotor_init_out), 32'({5'(l), 5'(m), 5'(r)}));
        check("set_count", 32'(bus.char_count), 32'd0);
        check("set_in_ready", 32'(bus.in_ready), 32'd0);
        check_steps("set", 0, 0, 0);
        @(negedge clk);
        check("set_pulse_end", 32'(bus.rotor_set_out), 32'd0);
        check("set_ready_after", 32'(bus.in_ready), 32'd1);
        ref_l = l; ref_m = m; ref_r = r; ref_count = 0;
    endtask

    // One full letter: accept, step, settle, capture, hold for stall cycles, drain
    task automatic encrypt(input int c, input int stall, input bit keep_valid);
        int sm, sl, nl, nm, nr, exp_char;
        wait_ready();
        sm = (ref_r == C_NR || ref_m == C_NM) ? 1 : 0;
        sl = (ref_m == C_NM) ? 1 : 0;
        nr = (ref_r + 1) % 26;
        nm = (ref_m + sm) % 26;
        nl = (ref_l + sl) % 26;
        exp_char = chain(c, nl, nm, nr);
        bus.in_valid = 1'b1;
        bus.in_char  = 5'(c);
        @(negedge clk);
        if (!keep_valid) bus.in_valid = 1'b0;
        check("step_in_ready", 32'(bus.in_ready), 32'd0);
        check_steps("step", 1, sm, sl);
        @(negedge clk);
        check("settle_path", 32'(bus.path_char_out), 32'(c));
        check_steps("settle", 0, 0, 0);
        @(negedge clk);
        check("capture_path", 32'(bus.path_char_out), 32'(c));
        check("capture_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("out_valid", 32'(bus.out_valid), 32'd1);
        check("out_char", 32'(bus.out_char), 32'(exp_char));
        check("out_count", 32'(bus.char_count), 32'((ref_count + 1) % 65536));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_char", 32'(bus.out_char), 32'(exp_char));
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("drain_valid", 32'(bus.out_valid), 32'd0);
        check("drain_in_ready", 32'(bus.in_ready), 32'd1);
        ref_r = nr; ref_m = nm; ref_l = nl;
        ref_count = (ref_count + 1) % 65536;
        check("rotor_r", 32'(env_r), 32'(ref_r));
        check("rotor_m", 32'(env_m), 32'(ref_m));
        check("rotor_l", 32'(env_l), 32'(ref_l));
    endtask

    task automatic bad_letter(input int c);
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_char  = 5'(c);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("err_pulse", 32'(bus.err_pulse), 32'd1);
        check("err_in_ready", 32'(bus.in_ready), 32'd1);
        check_steps("err", 0, 0, 0);
        @(negedge clk);
        check("err_pulse_end", 32'(bus.err_pulse), 32'd0);
        check("err_count", 32'(bus.char_count), 32'(ref_count));
        check_steps("err_after", 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_char"}, 32'(bus.out_char), 32'd0);
        check({tag, "_path"}, 32'(bus.path_char_out), 32'd0);
        check({tag, "_count"}, 32'(bus.char_count), 32'd0);
        check({tag, "_init"}, 32'(bus.rotor_init_out), 32'd0);
        check({tag, "_set"}, 32'(bus.rotor_set_out), 32'd0);
        check({tag, "_err"}, 32'(bus.err_pulse), 32'd0);
        check_steps(tag, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sm, sl;
        reset           = 1'b1;
        bus.set_req     = 1'b0;
        bus.init_pos_in = '0;
        bus.in_valid    = 1'b0;
        bus.in_char     = '0;
        bus.out_ready   = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        do_set(0, 0, 0);
        encrypt(0, 0, 1'b0);
        check("first_count", 32'(bus.char_count), 32'd1);
        do_set(0, 0, C_NR);
        encrypt(5, 0, 1'b0);
        do_set(0, C_NM, 5);
        encrypt(7, 10, 1'b1);
        bad_letter(27);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 7))
                0: do_set($urandom_range(0, 25),
                          ($urandom_range(0, 1) != 0) ? C_NM - $urandom_range(0, 1) : $urandom_range(0, 25),
                          ($urandom_range(0, 1) != 0) ? C_NR - $urandom_range(0, 1) : $urandom_range(0, 25));
                1: bad_letter($urandom_range(26, 31));
                default: encrypt($urandom_range(0, 25), $urandom_range(0, 3), 1'b0);
            endcase
        end

        // Reset while the letter sits in SETTLE: rotors have already stepped
        wait_ready();
        sm = (ref_r == C_NR || ref_m == C_NM) ? 1 : 0;
        sl = (ref_m == C_NM) ? 1 : 0;
        bus.in_valid = 1'b1;
        bus.in_char  = 5'd9;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_steps("rst_step", 1, sm, sl);
        @(negedge clk);
        check("rst_settle_path", 32'(bus.path_char_out), 32'd9);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("midreset");
        ref_r = (ref_r + 1) % 26;
        ref_m = (ref_m + sm) % 26;
        ref_l = (ref_l + sl) % 26;
        ref_count = 0;
        check("midreset_rotor_r", 32'(env_r), 32'(ref_r));
        @(negedge clk);
        check("midreset_ready", 32'(bus.in_ready), 32'd1);
        check("midreset_valid", 32'(bus.out_valid), 32'd0);

        // set_req and a letter together: the SET wins, the letter is dropped
        bus.set_req     = 1'b1;
        bus.init_pos_in = {5'd3, 5'd4, 5'd16};
        bus.in_valid    = 1'b1;
        bus.in_char     = 5'd12;
        @(negedge clk);
        bus.set_req  = 1'b0;
        bus.in_valid = 1'b0;
        check("both_set", 32'(bus.rotor_set_out), 32'd1);
        check("both_in_ready", 32'(bus.in_ready), 32'd0);
        check_steps("both", 0, 0, 0);
        @(negedge clk);
        check("both_ready_after", 32'(bus.in_ready), 32'd1);
        check_steps("both_after", 0, 0, 0);
        @(negedge clk);
        check("both_no_output", 32'(bus.out_valid), 32'd0);
        check("both_count", 32'(bus.char_count), 32'd0);
        ref_l = 3; ref_m = 4; ref_r = 16; ref_count = 0;
        encrypt(25, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
